sram_req_ctrl: RTL and testbench
================================

# sram_req_ctrl

Request-side controller for the dual-bank SRAM wrapper (two DW-bit banks sharing an address, read together as one 2*DW word, written one bank at a time via `sram_sel`). It accepts 2*DW-bit word read/write requests with byte-lane masks over a valid/ready interface. It sequences them into single-bank SRAM write cycles and registered reads, and returns read data over a valid/ready response channel. It sits between the GPU core's load/store path and the SRAM wrapper.

## Interface
- `DW`, 8, bank width in bits; the word is 2*DW.
- `AW`, 11, word address width.

- `clk` input 1: sole clock; all state updates on its rising edge.
- `rst` input 1: synchronous reset, active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: controller accepts a request this cycle.
- `req_we` input 1: 1 = write, 0 = read.
- `req_addr` input AW: word address.
- `req_wdata` input 2*DW: write data; `[DW-1:0]` is the low bank, `[2*DW-1:DW]` is the high bank.
- `req_wmask` input 2: bit0 enables the low-bank write, bit1 enables the high-bank write.
- `rsp_valid` output 1: response beat present.
- `rsp_ready` input 1: consumer takes the response.
- `rsp_rdata` output 2*DW: read data.
- `sram_cen` output 1: SRAM chip enable, active-low.
- `sram_wen` output 1: SRAM write enable, active-low.
- `sram_sel` output 1: bank select for writes; 0 = low bank, 1 = high bank.
- `sram_addr` output AW: SRAM address.
- `sram_din` output DW: SRAM write data.
- `sram_dout` input 2*DW: SRAM read data, valid the cycle after the read command is sampled.

## Operation
- **States:** IDLE, WR_LO, WR_HI, RD, RD_WAIT, RSP.
- **Handshake:** `req_ready` = (state == IDLE) && !rst. A request is accepted on an edge where `req_valid && req_ready`. Address, data and mask are latched at acceptance; request inputs are ignored otherwise.
- **SRAM outputs** are registered and decoded from the next state:
  - `sram_cen=0` in WR_LO, WR_HI and RD; otherwise `sram_cen=1`.
  - `sram_wen=0` only in WR_LO and WR_HI.
- **Write sequencing** from IDLE:
  - mask 2'b11: WR_LO, then WR_HI, then IDLE.
  - mask 2'b01: WR_LO, then IDLE.
  - mask 2'b10: WR_HI, then IDLE.
  - mask 2'b00: no SRAM cycle; stays IDLE and the request is consumed.
- **Write data by state:**
  - WR_LO drives `sram_sel=0` and `sram_din=wdata[DW-1:0]`.
  - WR_HI drives `sram_sel=1` and `sram_din=wdata[2*DW-1:DW]`.
- **Read:** IDLE → RD (`sram_cen=0`, `sram_wen=1`) → RD_WAIT → RSP. On the edge leaving RD_WAIT, `rsp_rdata` captures `sram_dout` unmodified (both banks).
- **Response:** RSP holds `rsp_valid=1` and a stable `rsp_rdata` until `rsp_ready`, then returns to IDLE. `rsp_rdata` keeps its last value after the handshake.
- **Single outstanding request:** no new request is accepted until the current one finishes (IDLE again).

## Timing
- **Reset values:**
  - `req_ready=0` while `rst` is high.
  - `rsp_valid=0`, `rsp_rdata=0`.
  - `sram_cen=1`, `sram_wen=1`, `sram_sel=0`, `sram_addr=0`, `sram_din=0`.
  - State = IDLE.
- **Read latency:** accept at edge E0; SRAM command is active in cycle E0–E1 and sampled at E1; `sram_dout` is valid in E1–E2 and captured at E2; `rsp_valid=1` from E2. Minimum 3 cycles from acceptance to the next `req_ready` when `rsp_ready` is held high.
- **Write occupancy:** 1 SRAM cycle per set mask bit. The next request can be accepted 1 cycle after the last write cycle (IDLE reached).
- **Reset mid-operation:** `rst` has priority.
  - All outputs take their reset values at the next edge and any in-flight request is dropped.
  - A write command already presented in the reset cycle completes in the SRAM.
  - A pending response is discarded.
- **Response with `rsp_ready` held high** on the first RSP cycle: the response lasts exactly 1 cycle.

## Configuration
- Macro `SRAM_CTRL_WR_ACK_EN`.
- **Defined:** every write, including mask 2'b00, ends in RSP with `rsp_valid=1` and `rsp_rdata=0`, using the same `rsp_ready` handshake as reads; mask 2'b00 goes straight IDLE → RSP.
- **Undefined:** writes are posted and produce no response beat; RSP is entered only for reads.

## Test plan
- **Full write then read:** write addr 0x005, data 0xBEEF, mask 2'b11 → WR_LO with `sram_din=0xEF`, `sel=0`, then WR_HI with `sram_din=0xBE`, `sel=1`. A subsequent read of 0x005 → `rsp_rdata=0xBEEF`, `rsp_valid` 3 cycles after acceptance.
- **Byte-masked write:** after 0xBEEF, write 0x1234 with mask 2'b10 to 0x005 → exactly one SRAM cycle with `sel=1`, `sram_din=0x12`. Readback = 0x12EF.
- **Response backpressure:** read 0x7FF with `rsp_ready=0` for 5 cycles → `rsp_valid` and `rsp_rdata` stable, `req_ready=0` throughout, `sram_cen=1` after RD. Raising `rsp_ready` → IDLE next cycle.
- **Reset mid-read:** assert `rst` in RD_WAIT → next cycle `rsp_valid=0`, `rsp_rdata=0`, `sram_cen=1`. After release `req_ready=1` and no response is emitted.
- **Empty mask:** write with mask 2'b00 → `sram_cen` stays 1 and `req_ready` returns high the next cycle (without the macro).
- **Write ack:** with `SRAM_CTRL_WR_ACK_EN`, write mask 2'b11 → `rsp_valid=1` with `rsp_rdata=0` on the cycle after WR_HI. Mask 2'b00 → `rsp_valid` 1 cycle after acceptance.

Source files
------------

// File: rtl/sram_req_ctrl.sv
// Sequences word read/write requests into single-bank SRAM cycles and read responses.
// Optional macro SRAM_CTRL_WR_ACK_EN: writes also return a zero-data response beat.
module sram_req_ctrl #(
  parameter int DW = 8,
  parameter int AW = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AW-1:0]     req_addr,
  input  logic [2*DW-1:0]   req_wdata,
  input  logic [1:0]        req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2*DW-1:0]   rsp_rdata,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic              sram_sel,
  output logic [AW-1:0]     sram_addr,
  output logic [DW-1:0]     sram_din,
  input  logic [2*DW-1:0]   sram_dout
);

`ifdef SRAM_CTRL_WR_ACK_EN
  localparam bit WrAck = 1'b1;
`else
  localparam bit WrAck = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_WR_LO, S_WR_HI, S_RD, S_RD_WAIT, S_RSP
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [2*DW-1:0]   wdata_q, wdata_d;
  logic              hi_pend_q, hi_pend_d;
  logic [2*DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              sram_cen_q, sram_cen_d;
  logic              sram_wen_q, sram_wen_d;
  logic              sram_sel_q, sram_sel_d;
  logic [AW-1:0]     sram_addr_q, sram_addr_d;
  logic [DW-1:0]     sram_din_q, sram_din_d;
  logic              accept;

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    hi_pend_d   = hi_pend_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          hi_pend_d = req_wmask[1];
          if (!req_we) begin
            state_d = S_RD;
          end else if (req_wmask[0]) begin
            state_d = S_WR_LO;
          end else if (req_wmask[1]) begin
            state_d = S_WR_HI;
          end else if (WrAck) begin
            state_d     = S_RSP;
            rsp_rdata_d = '0;
          end
        end
      end
      S_WR_LO: begin
        if (hi_pend_q) begin
          state_d = S_WR_HI;
        end else if (WrAck) begin
          state_d     = S_RSP;
          rsp_rdata_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_HI: begin
        if (WrAck) begin
          state_d     = S_RSP;
          rsp_rdata_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD:      state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        state_d     = S_RSP;
        rsp_rdata_d = sram_dout;
      end
      S_RSP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase

    // SRAM pins are decoded from the state being entered so they line up with it.
    sram_cen_d  = !(state_d == S_WR_LO || state_d == S_WR_HI || state_d == S_RD);
    sram_wen_d  = !(state_d == S_WR_LO || state_d == S_WR_HI);
    sram_sel_d  = (state_d == S_WR_HI);
    sram_addr_d = addr_d;
    sram_din_d  = sram_din_q;
    if (state_d == S_WR_LO) sram_din_d = wdata_d[DW-1:0];
    if (state_d == S_WR_HI) sram_din_d = wdata_d[2*DW-1:DW];
    rsp_valid_d = (state_d == S_RSP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      hi_pend_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_valid_q <= 1'b0;
      sram_cen_q  <= 1'b1;
      sram_wen_q  <= 1'b1;
      sram_sel_q  <= 1'b0;
      sram_addr_q <= '0;
      sram_din_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      hi_pend_q   <= hi_pend_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_valid_q <= rsp_valid_d;
      sram_cen_q  <= sram_cen_d;
      sram_wen_q  <= sram_wen_d;
      sram_sel_q  <= sram_sel_d;
      sram_addr_q <= sram_addr_d;
      sram_din_q  <= sram_din_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign sram_cen  = sram_cen_q;
  assign sram_wen  = sram_wen_q;
  assign sram_sel  = sram_sel_q;
  assign sram_addr = sram_addr_q;
  assign sram_din  = sram_din_q;

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl: dual-bank SRAM model, reference memory and response/write-cycle scoreboards.
module tb_sram_req_ctrl;
  localparam int DW = 8;
  localparam int AW = 11;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [AW-1:0]     req_addr;
  logic [2*DW-1:0]   req_wdata;
  logic [1:0]        req_wmask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [2*DW-1:0]   rsp_rdata;
  logic              sram_cen;
  logic              sram_wen;
  logic              sram_sel;
  logic [AW-1:0]     sram_addr;
  logic [DW-1:0]     sram_din;
  logic [2*DW-1:0]   sram_dout;

  sram_req_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_sel(sram_sel),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;

  logic [2*DW-1:0] mem     [0:(1<<AW)-1];
  logic [2*DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [2*DW-1:0] rsp_q [$];
  logic [31:0]     wr_q  [$];
  int n_chk = 0;
  int n_bad = 0;
  bit rnd_rdy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Dual-bank SRAM: reads return both banks the cycle after the command.
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_wen) begin
        if (sram_sel) mem[sram_addr][2*DW-1:DW] <= sram_din;
        else          mem[sram_addr][DW-1:0]    <= sram_din;
      end else begin
        sram_dout <= mem[sram_addr];
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (!sram_cen && !sram_wen) begin
        chk("wr_expected", 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) chk("wr_cycle", {12'd0, sram_addr, sram_sel, sram_din}, wr_q.pop_front());
      end
      if (rsp_valid && rsp_ready) begin
        chk("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
        if (rsp_q.size() != 0) chk("rsp_data", 32'(rsp_rdata), 32'(rsp_q.pop_front()));
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1 rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [2*DW-1:0] wdata,
                        input logic [1:0] mask, input bit exp_rsp);
    int b;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wmask = mask;
    b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (!req_ready && b < 200);
    chk("accept_timeout", 32'(req_ready), 32'd1);
    if (req_ready) begin
      if (we) begin
        if (mask[0]) begin
          wr_q.push_back({12'd0, addr, 1'b0, wdata[DW-1:0]});
          ref_mem[addr][DW-1:0] = wdata[DW-1:0];
        end
        if (mask[1]) begin
          wr_q.push_back({12'd0, addr, 1'b1, wdata[2*DW-1:DW]});
          ref_mem[addr][2*DW-1:DW] = wdata[2*DW-1:DW];
        end
`ifdef SRAM_CTRL_WR_ACK_EN
        rsp_q.push_back('0);
`endif
      end else if (exp_rsp) begin
        rsp_q.push_back(ref_mem[addr]);
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = 16'($urandom);
    req_wmask = 2'($urandom);
  endtask

  task automatic wait_idle();
    int b = 0;
    while (!req_ready && b < 200) begin
      @(negedge clk);
      b++;
    end
    chk("idle_timeout", 32'(req_ready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    rst = 1'b1; rsp_ready = 1'b1; req_valid = 1'b0;
    req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_cen", 32'(sram_cen), 32'd1);
    chk("rst_wen", 32'(sram_wen), 32'd1);
    chk("rst_sel", 32'(sram_sel), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_din", 32'(sram_din), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // full write then read
    do_req(1'b1, 11'h005, 16'hBEEF, 2'b11, 1'b1);
    @(negedge clk);
    chk("wlo_cen", 32'(sram_cen), 32'd0);
    chk("wlo_sel_din", {sram_wen, sram_sel, sram_din}, {1'b0, 1'b0, 8'hEF});
    @(negedge clk);
    chk("whi_sel_din", {sram_cen, sram_wen, sram_sel, sram_din}, {1'b0, 1'b0, 1'b1, 8'hBE});
    @(negedge clk);
`ifdef SRAM_CTRL_WR_ACK_EN
    chk("wack_valid", {rsp_valid, rsp_rdata}, {1'b1, 16'h0000});
`else
    chk("wr_done_ready", 32'(req_ready), 32'd1);
`endif
    wait_idle();
    do_req(1'b0, 11'h005, 16'h0, 2'b00, 1'b1);
    @(negedge clk);
    chk("rd_cmd", {rsp_valid, sram_cen, sram_wen}, {1'b0, 1'b0, 1'b1});
    @(negedge clk);
    chk("rd_wait", {rsp_valid, sram_cen}, {1'b0, 1'b1});
    @(negedge clk);
    chk("rd_rsp", {rsp_valid, rsp_rdata}, {1'b1, 16'hBEEF});
    @(negedge clk);
    chk("rd_idle_again", 32'(req_ready), 32'd1);

    // byte-masked write
    do_req(1'b1, 11'h005, 16'h1234, 2'b10, 1'b1);
    @(negedge clk);
    chk("mw_hi", {sram_cen, sram_wen, sram_sel, sram_din}, {1'b0, 1'b0, 1'b1, 8'h12});
    @(negedge clk);
    chk("mw_one_cycle", 32'(sram_cen), 32'd1);
    wait_idle();
    do_req(1'b0, 11'h005, 16'h0, 2'b00, 1'b1);
    wait_idle();

    // response backpressure
    do_req(1'b1, 11'h7FF, 16'hA55A, 2'b11, 1'b1);
    wait_idle();
    rsp_ready = 1'b0;
    do_req(1'b0, 11'h7FF, 16'h0, 2'b00, 1'b1);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", {rsp_valid, rsp_rdata, req_ready, sram_cen}, {1'b1, 16'hA55A, 1'b0, 1'b1});
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_busy", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("bp_release_idle", {req_ready, rsp_valid}, {1'b1, 1'b0});

    // reset mid-read
    do_req(1'b0, 11'h005, 16'h0, 2'b00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_outs", {rsp_valid, rsp_rdata, sram_cen, req_ready}, {1'b0, 16'h0000, 1'b1, 1'b0});
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mrst_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // empty mask
    do_req(1'b1, 11'h009, 16'hFFFF, 2'b00, 1'b1);
    @(negedge clk);
`ifdef SRAM_CTRL_WR_ACK_EN
    chk("empty_ack", {rsp_valid, rsp_rdata, sram_cen}, {1'b1, 16'h0000, 1'b1});
`else
    chk("empty_mask", {sram_cen, req_ready, rsp_valid}, {1'b1, 1'b1, 1'b0});
`endif
    wait_idle();

    // random mix with random response backpressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      do_req(1'($urandom), AW'($urandom_range(0, 7)), 16'($urandom), 2'($urandom_range(0, 3)), 1'b1);
    end
    rnd_rdy = 1'b0;
    @(posedge clk); #2 rsp_ready = 1'b1;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
